zx_vram_arbiter: RTL and testbench

ZX_VRAM_ARBITER -- requirements
Module: zx_vram_arbiter

---
 rtl/zx_video_pkg.sv | 12 +
 rtl/zx_scr_addr.sv | 19 +
 rtl/zx_vram_arbiter.sv | 132 +++++++++++++
 tb/tb_zx_vram_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/zx_video_pkg.sv
// Shared constants and FSM state type for the ZX-style VRAM arbiter.
package zx_video_pkg;
  localparam int ATTR_BASE  = 'h1800;
  localparam int WIN_SX_MIN = -8;
  localparam int WIN_SX_MAX = 247;
  localparam int WIN_SY_MAX = 191;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } cpu_st_e;
endpackage

// File: rtl/zx_scr_addr.sv
// Screen-memory address generator: line and cell column to bitmap/attribute byte address.
module zx_scr_addr #(
  parameter int                 VRAM_AW   = 13,
  parameter logic [VRAM_AW-1:0] ATTR_BASE = 13'h1800
) (
  input  logic [7:0]         i_sy,
  input  logic [4:0]         i_col,
  output logic [VRAM_AW-1:0] o_bm_addr,
  output logic [VRAM_AW-1:0] o_at_addr
);
  logic [12:0] w_bm;
  logic [9:0]  w_at;

  // Bitmap rows are interleaved: third, pixel row in char, char row, column.
  assign w_bm      = {i_sy[7:6], i_sy[2:0], i_sy[5:3], i_col};
  assign w_at      = {i_sy[7:3], i_col};
  assign o_bm_addr = VRAM_AW'(w_bm);
  assign o_at_addr = ATTR_BASE + VRAM_AW'(w_at);
endmodule

// File: rtl/zx_vram_arbiter.sv
// Single-port VRAM arbiter: video fetches bitmap/attribute at phases 0/1 of each
// 8-pixel cell, the CPU gets every other cycle through a two-state access FSM.
module zx_vram_arbiter #(
  parameter int                 CORDW     = 11,
  parameter int                 VRAM_AW   = 13,
  parameter logic [VRAM_AW-1:0] ATTR_BASE = VRAM_AW'(zx_video_pkg::ATTR_BASE)
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_screen,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic                    i_cpu_req,
  input  logic                    i_cpu_we,
  input  logic [VRAM_AW-1:0]      i_cpu_addr,
  input  logic [7:0]              i_cpu_wdata,
  output logic                    o_cpu_ack,
  output logic [7:0]              o_cpu_rdata,
  output logic                    o_cpu_wait,
  output logic [VRAM_AW-1:0]      o_vram_addr,
  output logic                    o_vram_we,
  output logic [7:0]              o_vram_wdata,
  input  logic [7:0]              i_vram_rdata,
  output logic [7:0]              o_pix_bits,
  output logic [7:0]              o_pix_attr,
  output logic                    o_pix_load
);
  import zx_video_pkg::*;

  localparam logic signed [CORDW-1:0] SX_MIN = CORDW'(WIN_SX_MIN);
  localparam logic signed [CORDW-1:0] SX_MAX = CORDW'(WIN_SX_MAX);
  localparam logic signed [CORDW-1:0] SY_MAX = CORDW'(WIN_SY_MAX);
  localparam logic signed [CORDW-1:0] SX_OFF = CORDW'(8);

  cpu_st_e            r_state;
  logic               r_ack;
  logic [VRAM_AW-1:0] r_last_addr;
  logic               r_fetch_bm, r_fetch_at;
  logic [7:0]         r_stg_bits, r_stg_attr;
  logic [7:0]         r_pix_bits, r_pix_attr;
  logic               r_pix_load;

  logic signed [CORDW-1:0] w_sx8;
  logic [2:0]              w_phase;
  logic                    w_in_win, w_vid_own, w_vid_issue, w_cpu_issue, w_cell_end;
  logic [VRAM_AW-1:0]      w_bm_addr, w_at_addr, w_addr;
  logic                    w_unused;

  assign w_sx8      = i_sx + SX_OFF;
  assign w_phase    = i_sx[2:0];
  assign w_in_win   = (i_sy >= '0) && (i_sy <= SY_MAX) && (i_sx >= SX_MIN) && (i_sx <= SX_MAX);
  assign w_vid_own  = w_in_win && (w_phase <= 3'd1);
  assign w_cell_end = w_in_win && (w_phase == 3'd7);
  assign w_unused   = ^{i_screen, w_sx8[CORDW-1:8], w_sx8[2:0]};

  zx_scr_addr #(
    .VRAM_AW   (VRAM_AW),
    .ATTR_BASE (ATTR_BASE)
  ) u_scr_addr (
    .i_sy      (i_sy[7:0]),
    .i_col     (w_sx8[7:3]),
    .o_bm_addr (w_bm_addr),
    .o_at_addr (w_at_addr)
  );

  // Nothing issues while reset is asserted, so the port falls back to the held address.
  assign w_vid_issue = i_rst_n && w_vid_own;
  assign w_cpu_issue = i_rst_n && !w_vid_own && i_cpu_req && (r_state == ST_IDLE);

  always_comb begin
    w_addr = r_last_addr;
    if (w_vid_issue)      w_addr = w_phase[0] ? w_at_addr : w_bm_addr;
    else if (w_cpu_issue) w_addr = i_cpu_addr;
  end

  assign o_vram_addr  = w_addr;
  assign o_vram_we    = w_cpu_issue && i_cpu_we;
  assign o_vram_wdata = i_cpu_wdata;
  assign o_cpu_wait   = i_rst_n && i_cpu_req && (r_state == ST_IDLE) && w_vid_own;
  assign o_cpu_ack    = r_ack && i_rst_n;
  assign o_cpu_rdata  = i_vram_rdata;
  assign o_pix_bits   = r_pix_bits;
  assign o_pix_attr   = r_pix_attr;
  assign o_pix_load   = r_pix_load;

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= w_cpu_issue;
          if (w_cpu_issue) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data returns one cycle after each fetch; staging is copied out at cell end.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      r_last_addr <= '0;
      r_fetch_bm  <= 1'b0;
      r_fetch_at  <= 1'b0;
      r_stg_bits  <= '0;
      r_stg_attr  <= '0;
      r_pix_bits  <= '0;
      r_pix_attr  <= '0;
      r_pix_load  <= 1'b0;
    end else begin
      r_last_addr <= w_addr;
      r_fetch_bm  <= w_vid_issue && (w_phase == 3'd0);
      r_fetch_at  <= w_vid_issue && (w_phase == 3'd1);
      if (r_fetch_bm) r_stg_bits <= i_vram_rdata;
      if (r_fetch_at) r_stg_attr <= i_vram_rdata;
      r_pix_load <= w_cell_end;
      if (w_cell_end) begin
        r_pix_bits <= r_stg_bits;
        r_pix_attr <= r_stg_attr;
      end
    end
  end
endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Bench for zx_vram_arbiter: address table, hand-written CPU/reset sequences and
// a randomized frame checked against an arithmetic reference model.
module tb_zx_vram_arbiter;
  localparam int ATTR = 'h1800;

  logic               clk, rst_n, screen;
  logic signed [10:0] sx, sy;
  logic               cpu_req, cpu_we;
  logic [12:0]        cpu_addr, vram_addr;
  logic [7:0]         cpu_wdata, cpu_rdata, vram_wdata, ram_q, pix_bits, pix_attr;
  logic               cpu_ack, cpu_wait, vram_we, pix_load;

  zx_vram_arbiter dut (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_screen(screen), .i_sx(sx), .i_sy(sy),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_wait(cpu_wait),
    .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_wdata(vram_wdata),
    .i_vram_rdata(ram_q), .o_pix_bits(pix_bits), .o_pix_attr(pix_attr), .o_pix_load(pix_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign screen = (sy >= 0) && (sy <= 191) && (sx >= 0) && (sx <= 255);

  // Synchronous single-port RAM, read-before-write.
  logic [7:0] ram     [8192];
  logic [7:0] ref_mem [8192];
  always @(posedge clk) begin
    ram_q <= ram[vram_addr];
    if (vram_we) ram[vram_addr] = vram_wdata;
  end

  int n_chk = 0, n_err = 0, line_loads = 0, n_reads = 0;

  // Reference model state
  bit         m_valid = 0, m_busy = 0, m_rd = 0, m_load = 0;
  int         m_last = 0, m_exp_rd = 0, m_bits = 0, m_attr = 0, st_b = 0, st_a = 0;
  // DUT outputs sampled at the check point of the last cycle
  logic       s_wait, s_ack, s_we, s_load;
  logic [7:0] s_rdata, s_bits, s_attr;
  logic [12:0] s_addr;

  typedef struct { int sy; int col; int bm; int at; } vec_t;
  vec_t vec [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h sx=%0d sy=%0d t=%0t", nm, act, exp, sx, sy, $time);
    end
  endtask

  function automatic int bm_addr(int y, int c);
    return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + c;
  endfunction

  function automatic int at_addr(int y, int c);
    return (ATTR + (y / 8) * 32 + c) % 8192;
  endfunction

  // Called with inputs already applied at the falling edge; checks, advances the
  // model across the next rising edge, and returns at the following falling edge.
  task automatic tick();
    int  sxv, syv, p, col, ea;
    bit  win, vid, ivid, icpu;
    #1;
    sxv  = int'(sx);
    syv  = int'(sy);
    win  = (syv >= 0) && (syv <= 191) && (sxv >= -8) && (sxv <= 247);
    p    = ((sxv % 8) + 8) % 8;
    col  = (sxv + 8) / 8;
    vid  = win && (p < 2);
    ivid = rst_n && vid;
    icpu = rst_n && cpu_req && !vid && !m_busy;
    ea   = ivid ? ((p == 0) ? bm_addr(syv, col) : at_addr(syv, col)) :
           icpu ? int'(cpu_addr) : m_last;
    s_wait = cpu_wait; s_ack = cpu_ack; s_we = vram_we; s_load = pix_load;
    s_rdata = cpu_rdata; s_bits = pix_bits; s_attr = pix_attr; s_addr = vram_addr;
    if (pix_load) line_loads++;
    if (m_valid) begin
      chk("vram_addr", 32'(vram_addr), 32'(ea));
      chk("vram_we",   32'(vram_we), 32'(icpu && cpu_we));
      if (icpu && cpu_we) chk("vram_wdata", 32'(vram_wdata), 32'(cpu_wdata));
      chk("cpu_wait",  32'(cpu_wait), 32'(rst_n && cpu_req && !m_busy && vid));
      chk("cpu_ack",   32'(cpu_ack), 32'(rst_n && m_busy));
      if (rst_n && m_busy && m_rd) begin
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_exp_rd));
        n_reads++;
      end
      chk("pix_load",  32'(pix_load), 32'(m_load));
      chk("pix_bits",  32'(pix_bits), 32'(m_bits));
      chk("pix_attr",  32'(pix_attr), 32'(m_attr));
    end
    if (!rst_n) begin
      m_valid = 1; m_busy = 0; m_last = 0; m_load = 0;
      m_bits = 0; m_attr = 0; st_b = 0; st_a = 0;
    end else begin
      if (icpu) begin
        m_rd     = !cpu_we;
        m_exp_rd = int'(ref_mem[cpu_addr]);
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      end
      m_busy = icpu;
      if (ivid || icpu) m_last = ea;
      if (ivid && p == 0) st_b = int'(ref_mem[ea]);
      if (ivid && p == 1) st_a = int'(ref_mem[ea]);
      m_load = win && (p == 7);
      if (m_load) begin m_bits = st_b; m_attr = st_a; end
    end
    @(negedge clk);
  endtask

  task automatic poke(input int a, input int d);
    ram[a]     = 8'(d);
    ref_mem[a] = 8'(d);
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 8192; i++) poke(i, $urandom_range(0, 255));
    poke('h0000, 'hA5); poke('h1800, 'h3C); poke('h1234, 'h5A);
    vec[0] = '{0,   0,  'h0000, 'h1800};
    vec[1] = '{71,  5,  'h0F05, 'h1905};
    vec[2] = '{191, 31, 'h17FF, 'h1AFF};
    vec[3] = '{1,   0,  'h0100, 'h1800};
    vec[4] = '{8,   1,  'h0021, 'h1821};
    vec[5] = '{64,  16, 'h0810, 'h1910};
    vec[6] = '{130, 10, 'h120A, 'h1A0A};

    rst_n = 0; sx = -11'sd8; sy = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    @(negedge clk);

    // Reset holds every output low even with a pending CPU request in a video cycle
    tick(); tick();
    chk("rst_wait", 32'(s_wait), 0); chk("rst_ack", 32'(s_ack), 0);
    chk("rst_we", 32'(s_we), 0);     chk("rst_addr", 32'(s_addr), 0);
    chk("rst_load", 32'(s_load), 0); chk("rst_bits", 32'(s_bits), 0);
    chk("rst_attr", 32'(s_attr), 0);
    rst_n = 1; cpu_req = 0;

    // First cell of line 0: fetches at sx=-8/-7, load visible at sx=0
    sy = 0;
    for (int x = -8; x <= 0; x++) begin
      sx = 11'(x);
      tick();
      if (x == -8) chk("c0_bm_addr", 32'(s_addr), 'h0000);
      if (x == -7) chk("c0_at_addr", 32'(s_addr), 'h1800);
      if (x == -1) chk("c0_no_load", 32'(s_load), 0);
    end
    chk("c0_load", 32'(s_load), 1);
    chk("c0_bits", 32'(s_bits), 'hA5);
    chk("c0_attr", 32'(s_attr), 'h3C);

    // Address table
    for (int i = 0; i < 7; i++) begin
      sy = 11'(vec[i].sy); sx = 11'(8 * vec[i].col - 8);
      tick();
      chk("tbl_bm", 32'(s_addr), 32'(vec[i].bm));
      sx = 11'(8 * vec[i].col - 7);
      tick();
      chk("tbl_at", 32'(s_addr), 32'(vec[i].at));
    end

    // CPU read arriving at phase 0 inside the window
    sy = 10; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1234;
    sx = 16; tick(); chk("rd_wait_p0", 32'(s_wait), 1); chk("rd_ack_p0", 32'(s_ack), 0);
    sx = 17; tick(); chk("rd_wait_p1", 32'(s_wait), 1);
    sx = 18; tick(); chk("rd_wait_p2", 32'(s_wait), 0); chk("rd_issue_addr", 32'(s_addr), 'h1234);
    chk("rd_issue_we", 32'(s_we), 0);
    sx = 19; tick(); chk("rd_ack_p3", 32'(s_ack), 1); chk("rd_data", 32'(s_rdata), 'h5A);
    cpu_req = 0;

    // Continuous writes outside the window: one ack every second cycle
    sy = 200; cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0400; cpu_wdata = 8'h70;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      sx = 11'(100 + k);
      tick();
      if (s_ack) begin
        acks++;
        cpu_addr = 13'(13'h0400 + acks);
        cpu_wdata = 8'(8'h70 + acks);
      end
    end
    cpu_req = 0; sx = 110; tick();
    chk("wr_ack_count", 32'(acks), 5);
    for (int j = 0; j < 5; j++) chk("wr_ram", 32'(ram['h0400 + j]), 32'('h70 + j));

    // Reset during ACCESS abandons the access
    sy = 200; sx = 50; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0123;
    tick(); chk("ra_issue_addr", 32'(s_addr), 'h0123);
    rst_n = 0; sx = 51;
    tick(); chk("ra_no_ack", 32'(s_ack), 0);
    rst_n = 1; cpu_req = 0; sx = 52;
    tick();
    chk("ra_ack", 32'(s_ack), 0);   chk("ra_wait", 32'(s_wait), 0);
    chk("ra_we", 32'(s_we), 0);     chk("ra_addr", 32'(s_addr), 0);
    chk("ra_load", 32'(s_load), 0); chk("ra_bits", 32'(s_bits), 0);
    chk("ra_attr", 32'(s_attr), 0);

    // Full frame with random CPU traffic
    for (int y = 0; y < 196; y++) begin
      line_loads = 0;
      for (int x = -16; x < 256; x++) begin
        if (cpu_req && s_ack) cpu_req = 0;
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
          cpu_req   = 1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 13'($urandom_range(0, 8191));
          cpu_wdata = 8'($urandom_range(0, 255));
        end
        sx = 11'(x); sy = 11'(y);
        tick();
      end
      chk("loads_per_line", 32'(line_loads), (y <= 191) ? 32 : 0);
    end
    chk("reads_scoreboarded", 32'(n_reads > 100), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
